// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: plays the LCD init sequence, then round-robin arbitrates two byte-write clients onto one controller
module lcd_cmd_arbiter #(
  parameter int DLY_W = 18,
  parameter logic [DLY_W-1:0] DLY_MAX = 18'h3FFFE
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ0,
  input  logic       iREQ1,
  input  logic [7:0] iDATA0,
  input  logic [7:0] iDATA1,
  input  logic       iRS0,
  input  logic       iRS1,
  output logic       oACK0,
  output logic       oACK1,
  output logic       oBUSY,
  output logic       oINIT_DONE,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_Start,
  input  logic       iLCD_Done
);
  typedef enum logic [1:0] {ARB, START, DLY, DONE} state_t;
  state_t r_state, w_state_n;
  logic [2:0] r_idx, w_idx_n;
  logic [DLY_W-1:0] r_cnt, w_cnt_n;
  logic [7:0] r_data, w_data_n, w_init_cmd;
  logic r_rr, w_rr_n, r_init_done, w_init_done_n, r_ack0, w_ack0_n, r_ack1, w_ack1_n;
  logic r_busy, r_rs, w_rs_n, r_start, w_start_n;
  logic w_init_pend, w_cli, w_win;
  assign w_init_cmd = r_idx == 3'd0 ? 8'h38 : r_idx == 3'd1 ? 8'h0C : r_idx == 3'd2 ? 8'h01 :
                      r_idx == 3'd3 ? 8'h06 : 8'h80;
  assign w_init_pend = !r_init_done && (r_idx < 3'd5);
  assign w_cli = r_init_done && (iREQ0 || iREQ1);
  assign w_win = (iREQ0 && iREQ1) ? r_rr : iREQ1;
  // DONE arbitrates like ARB so a pending command costs no extra idle cycle
  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_cnt_n = r_cnt;
    w_data_n = r_data;
    w_rs_n = r_rs;
    w_rr_n = r_rr;
    w_init_done_n = r_init_done;
    w_ack0_n = 1'b0;
    w_ack1_n = 1'b0;
    w_start_n = r_start;
    case (r_state)
      ARB, DONE: begin
        if (r_state == DONE && !r_init_done && r_idx == 3'd5) w_init_done_n = 1'b1;
        if (w_init_pend || w_cli) begin
          w_state_n = START;
          w_start_n = 1'b1;
          w_data_n = w_init_pend ? w_init_cmd : (w_win ? iDATA1 : iDATA0);
          w_rs_n = !w_init_pend && (w_win ? iRS1 : iRS0);
          w_idx_n = w_init_pend ? r_idx + 3'd1 : r_idx;
          w_ack0_n = !w_init_pend && !w_win;
          w_ack1_n = !w_init_pend && w_win;
          w_rr_n = w_init_pend ? r_rr : !w_win;
        end else begin
          w_state_n = ARB;
        end
      end
      START: begin
        if (iLCD_Done) begin
          w_start_n = 1'b0;
          w_cnt_n = '0;
          w_state_n = DLY;
        end
      end
      DLY: begin
        if (r_cnt < DLY_MAX) begin
          w_cnt_n = r_cnt + DLY_W'(1);
        end else begin
          w_cnt_n = '0;
          w_state_n = DONE;
        end
      end
      default: w_state_n = ARB;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ARB;
      r_idx <= '0;
      r_cnt <= '0;
      r_data <= '0;
      r_rs <= 1'b0;
      r_rr <= 1'b0;
      r_init_done <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_start <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_cnt <= w_cnt_n;
      r_data <= w_data_n;
      r_rs <= w_rs_n;
      r_rr <= w_rr_n;
      r_init_done <= w_init_done_n;
      r_ack0 <= w_ack0_n;
      r_ack1 <= w_ack1_n;
      r_start <= w_start_n;
      r_busy <= w_state_n != ARB;
    end
  end
  assign oACK0 = r_ack0;
  assign oACK1 = r_ack1;
  assign oBUSY = r_busy;
  assign oINIT_DONE = r_init_done;
  assign oLCD_DATA = r_data;
  assign oLCD_RS = r_rs;
  assign oLCD_Start = r_start;
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter: directed bench with a done-after-3-cycles controller model and DLY_MAX=4
module tb_lcd_cmd_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0, spur = 1'b0, done_m = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, ldata;
  logic ack0, ack1, busy, idone, lrs, lstart, lcd_done;
  assign lcd_done = done_m | spur;
  lcd_cmd_arbiter #(.DLY_W(3), .DLY_MAX(3'd4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ0(req0), .iREQ1(req1), .iDATA0(d0), .iDATA1(d1),
    .iRS0(rs0), .iRS1(rs1), .oACK0(ack0), .oACK1(ack1), .oBUSY(busy), .oINIT_DONE(idone),
    .oLCD_DATA(ldata), .oLCD_RS(lrs), .oLCD_Start(lstart), .iLCD_Done(lcd_done)
  );
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int c = 0;
  always @(posedge clk) begin
    if (!lstart) begin
      c <= 0;
      done_m <= 1'b0;
    end else begin
      c <= c + 1;
      done_m <= (c == 1);
    end
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] q_data[$];
  logic q_rs[$];
  int q_cyc[$], q_ack[$];
  logic p_start = 1'b0, p_idone = 1'b0;
  int st_run = 0, bz_run = 0, a0_run = 0, a1_run = 0, st_len = 0, bz_len = 0, a0_len = 0, a1_len = 0;
  int acks_init = 0, idone_cyc = -1, a1_cyc = -1;
  always @(negedge clk) begin
    if (lstart && !p_start) begin
      q_data.push_back(ldata);
      q_rs.push_back(lrs);
      q_cyc.push_back(cyc);
    end
    if (ack0) q_ack.push_back(0);
    if (ack1) q_ack.push_back(1);
    if (ack1) a1_cyc <= cyc;
    if (idone && !p_idone) idone_cyc <= cyc;
    if ((ack0 || ack1) && !idone) acks_init <= acks_init + 1;
    p_start <= lstart;
    p_idone <= idone;
    st_run <= lstart ? st_run + 1 : 0;
    bz_run <= busy ? bz_run + 1 : 0;
    a0_run <= ack0 ? a0_run + 1 : 0;
    a1_run <= ack1 ? a1_run + 1 : 0;
    if (!lstart && st_run != 0) st_len <= st_run;
    if (!busy && bz_run != 0) bz_len <= bz_run;
    if (!ack0 && a0_run != 0) a0_len <= a0_run;
    if (!ack1 && a1_run != 0) a1_len <= a1_run;
  end
  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("busy_wait", busy, 1'b0);
    @(negedge clk);
  endtask
  task automatic send(input bit cl, input logic [7:0] d, input logic r);
    if (cl) begin req1 = 1'b1; d1 = d; rs1 = r; end
    else begin req0 = 1'b1; d0 = d; rs0 = r; end
    for (int i = 0; i < 100 && !(cl ? ack1 : ack0); i++) @(negedge clk);
    check("ack_wait", cl ? ack1 : ack0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();
  endtask
  logic [7:0] init_tab[5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
  int n, na, k;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {ack0, ack1, busy, idone, ldata, lrs, lstart}, 14'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !idone; i++) @(negedge clk);
    check("init_timeout", idone, 1'b1);
    @(negedge clk);
    check("init_cnt", q_data.size(), 5);
    for (int i = 0; i < 5; i++) if (i < q_data.size()) begin
      check($sformatf("init_dat%0d", i), q_data[i], init_tab[i]);
      check($sformatf("init_rs%0d", i), q_rs[i], 1'b0);
      if (i > 0) check($sformatf("init_per%0d", i), q_cyc[i] - q_cyc[i-1], 9);
    end
    if (q_cyc.size() == 5) check("idone_time", idone_cyc - q_cyc[4], 9);
    check("no_ack_init", acks_init, 0);
    check("busy_idle", busy, 1'b0);
    n = q_data.size();
    send(1'b0, 8'h4D, 1'b1);
    check("c0_cnt", q_data.size(), n + 1);
    if (q_data.size() > n) begin
      check("c0_data", q_data[n], 8'h4D);
      check("c0_rs", q_rs[n], 1'b1);
    end
    check("c0_ack_len", a0_len, 1);
    check("c0_start_len", st_len, 3);
    check("c0_busy_len", bz_len, 9);
    n = q_data.size();
    send(1'b1, 8'h5A, 1'b0);
    if (q_data.size() > n) check("c1_data", q_data[n], 8'h5A);
    check("c1_ack_len", a1_len, 1);
    n = q_data.size();
    na = q_ack.size();
    k = 0;
    d0 = 8'hA1; rs0 = 1'b0; d1 = 8'hB2; rs1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) k++;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    check("rr_acks", k, 4);
    check("rr_cnt", q_data.size(), n + 4);
    for (int j = 0; j < 4; j++) if (q_data.size() > n + j && q_ack.size() > na + j) begin
      check($sformatf("rr_who%0d", j), q_ack[na+j], j % 2);
      check($sformatf("rr_dat%0d", j), q_data[n+j], (j % 2) ? 8'hB2 : 8'hA1);
      check($sformatf("rr_rs%0d", j), q_rs[n+j], (j % 2) ? 1'b1 : 1'b0);
    end
    req0 = 1'b1; d0 = 8'h77;
    for (int i = 0; i < 100 && !ack0; i++) @(negedge clk);
    req0 = 1'b0;
    check("mid_start", lstart, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {ack0, ack1, busy, idone, ldata, lrs, lstart}, 14'h0);
    req1 = 1'b1; d1 = 8'hC3; rs1 = 1'b1;
    n = q_data.size();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !ack1; i++) @(negedge clk);
    check("late_ack1", ack1, 1'b1);
    req1 = 1'b0;
    @(negedge clk);
    check("late_no_ack_init", acks_init, 0);
    check("late_ack1_time", a1_cyc - idone_cyc, 1);
    if (q_data.size() > n + 5) begin
      check("replay_first", q_data[n], 8'h38);
      check("late_data", q_data[n+5], 8'hC3);
    end
    wait_idle();
    n = q_data.size();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_arb_start", q_data.size(), n);
    check("spur_arb_busy", busy, 1'b0);
    req0 = 1'b1; d0 = 8'hE5; rs0 = 1'b1;
    for (int i = 0; i < 100 && !ack0; i++) @(negedge clk);
    req0 = 1'b0;
    for (int i = 0; i < 100 && lstart; i++) @(negedge clk);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("spur_dly_cnt", q_data.size(), n + 1);
    check("spur_dly_busy", bz_len, 9);
    if (q_data.size() > n) check("spur_dly_data", q_data[n], 8'hE5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
